// File: rtl/burst_ecc_seq_decoder_if.sv
// rtl/burst_ecc_seq_decoder_if.sv - codeword in / decoded result out handshake bundle
interface burst_ecc_seq_decoder_if #(
  parameter int N = 24,
  parameter int K = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_cw;
  logic         corr_en;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] out_msg;
  logic         out_corr;
  logic         out_uncorr;
  logic [15:0]  cnt_corr;
  logic [15:0]  cnt_uncorr;

  modport master (
    output in_valid, in_cw, corr_en, out_ready,
    input  in_ready, out_valid, out_msg, out_corr, out_uncorr, cnt_corr, cnt_uncorr
  );

  modport slave (
    input  in_valid, in_cw, corr_en, out_ready,
    output in_ready, out_valid, out_msg, out_corr, out_uncorr, cnt_corr, cnt_uncorr
  );
endinterface

// File: rtl/burst_ecc_seq_decoder.sv
// rtl/burst_ecc_seq_decoder.sv - bit-serial error-trapping decoder for a shortened burst-correcting cyclic code
module burst_ecc_seq_decoder #(
  parameter int             N     = 24,
  parameter int             K     = 16,
  parameter int             B     = 3,
  parameter int             N_CYC = 35,
  parameter logic [N-K:0]   G     = 9'h16B
) (
  input  logic                  clk,
  input  logic                  rst_n,
  burst_ecc_seq_decoder_if.slave bus
);
  localparam int R  = N - K;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N_CYC + 1);
  localparam int PW = $clog2(N_CYC + B + 1);

  typedef enum logic [1:0] {IDLE, SYND, TRAP, DONE} state_t;

  state_t          state;
  logic [N-1:0]    cw_q;
  logic            ce_q;
  logic [R-1:0]    s_q;
  logic [CW-1:0]   bit_cnt;
  logic [IW-1:0]   i_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [K-1:0]    msg_q;
  logic            corr_q;
  logic            uncorr_q;
  logic [15:0]     cnt_corr_q;
  logic [15:0]     cnt_uncorr_q;

  logic [CW-1:0]   bit_idx;
  logic            cur_bit;
  logic            trapped;
  logic            trap_bad;
  logic [N-1:0]    emask;
  logic [PW-1:0]   pos;
  logic            fin;
  logic            fin_corr;
  logic            fin_unc;
  logic [N-1:0]    fixed_cw;

  // One step of the divide-by-g(x) register: v*x + b, reduced mod g(x).
  function automatic logic [R-1:0] mulx(input logic [R-1:0] v, input logic b);
    return {v[R-2:0], b} ^ (v[R-1] ? G[R-1:0] : '0);
  endfunction

  assign bit_idx = CW'(N - 1) - bit_cnt;
  assign cur_bit = cw_q[bit_idx];
  assign trapped = (s_q[R-1:B] == '0);

  // Low bit j of the trapped register sits at codeword position (j - i) mod N_CYC.
  always_comb begin
    emask    = '0;
    trap_bad = 1'b0;
    pos      = '0;
    for (int j = 0; j < B; j++) begin
      pos = PW'(j + N_CYC) - PW'(i_q);
      if (pos >= PW'(N_CYC)) pos = pos - PW'(N_CYC);
      if (s_q[j]) begin
        if (pos >= PW'(N)) trap_bad = 1'b1;
        for (int k = 0; k < N; k++)
          if (pos == PW'(k)) emask[k] = 1'b1;
      end
    end
  end

  always_comb begin
    fin      = 1'b0;
    fin_corr = 1'b0;
    fin_unc  = 1'b0;
    case (state)
      SYND: if (bit_cnt == CW'(N)) begin
        if (s_q == '0) begin
          fin = 1'b1;
        end else if (!ce_q) begin
          fin     = 1'b1;
          fin_unc = 1'b1;
        end
      end
      TRAP: if (trapped) begin
        fin      = 1'b1;
        fin_corr = !trap_bad;
        fin_unc  = trap_bad;
      end else if (i_q == IW'(N_CYC - 1)) begin
        fin     = 1'b1;
        fin_unc = 1'b1;
      end
      default: ;
    endcase
    fixed_cw = fin_corr ? (cw_q ^ emask) : cw_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cw_q         <= '0;
      ce_q         <= 1'b0;
      s_q          <= '0;
      bit_cnt      <= '0;
      i_q          <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      msg_q        <= '0;
      corr_q       <= 1'b0;
      uncorr_q     <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && in_ready_q) begin
          cw_q       <= bus.in_cw;
          ce_q       <= bus.corr_en;
          s_q        <= '0;
          bit_cnt    <= '0;
          in_ready_q <= 1'b0;
          state      <= SYND;
        end
        SYND: if (bit_cnt != CW'(N)) begin
          s_q     <= mulx(s_q, cur_bit);
          bit_cnt <= bit_cnt + CW'(1);
        end else if (!fin) begin
          i_q   <= '0;
          state <= TRAP;
        end
        TRAP: if (!fin) begin
          s_q <= mulx(s_q, 1'b0);
          i_q <= i_q + IW'(1);
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Result and counters are captured once, on the transition into DONE.
      if (fin) begin
        state       <= DONE;
        out_valid_q <= 1'b1;
        cw_q        <= fixed_cw;
        msg_q       <= fixed_cw[N-1:R];
        corr_q      <= fin_corr;
        uncorr_q    <= fin_unc;
        if (fin_corr && cnt_corr_q != 16'hFFFF) cnt_corr_q <= cnt_corr_q + 16'd1;
        if (fin_unc && cnt_uncorr_q != 16'hFFFF) cnt_uncorr_q <= cnt_uncorr_q + 16'd1;
      end
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_msg    = msg_q;
  assign bus.out_corr   = corr_q;
  assign bus.out_uncorr = uncorr_q;
  assign bus.cnt_corr   = cnt_corr_q;
  assign bus.cnt_uncorr = cnt_uncorr_q;
endmodule

// File: tb/tb_burst_ecc_seq_decoder.sv
// tb/tb_burst_ecc_seq_decoder.sv - table and scoreboard bench for the sequential burst decoder
module tb_burst_ecc_seq_decoder;
  localparam logic [8:0] GP = 9'h16B;

  typedef struct {
    logic [23:0] cw;
    logic        ce;
    logic [15:0] msg;
    logic        corr;
    logic        uncorr;
  } vec_t;

  typedef struct {
    logic [15:0] msg;
    logic        corr;
    logic        uncorr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_cc = '0;
  logic [15:0] exp_cu = '0;
  exp_t sb[$];
  vec_t tbl[$];

  burst_ecc_seq_decoder_if bus();

  burst_ecc_seq_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] enc(input logic [15:0] m);
    logic [23:0] v;
    logic [23:0] g;
    v = {m, 8'h00};
    g = 24'(GP);
    for (int b = 23; b >= 8; b--)
      if (v[b]) v = v ^ (g << (b - 8));
    return {m, v[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [23:0] cw, input logic ce, input exp_t e);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_cw    = cw;
    bus.corr_en  = ce;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic collect(output int lat, input bit ack);
    exp_t e;
    lat = 0;
    while (!bus.out_valid && lat < 120) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.out_valid) begin
      total++; bad++;
      $display("FAIL out_valid_timeout: got 0 want 1 within 120 cycles");
      return;
    end
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty: got result want none");
      return;
    end
    e = sb.pop_front();
    if (e.corr && exp_cc != 16'hFFFF) exp_cc = exp_cc + 16'd1;
    if (e.uncorr && exp_cu != 16'hFFFF) exp_cu = exp_cu + 16'd1;
    chk("out_msg", {16'd0, bus.out_msg}, {16'd0, e.msg});
    chk("out_corr", {31'd0, bus.out_corr}, {31'd0, e.corr});
    chk("out_uncorr", {31'd0, bus.out_uncorr}, {31'd0, e.uncorr});
    chk("cnt_corr", {16'd0, bus.cnt_corr}, {16'd0, exp_cc});
    chk("cnt_uncorr", {16'd0, bus.cnt_uncorr}, {16'd0, exp_cu});
    if (ack) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    int seen;
    int cnt_nz;
    logic [23:0] bw;

    bus.in_valid  = 1'b0;
    bus.in_cw     = '0;
    bus.corr_en   = 1'b0;
    bus.out_ready = 1'b1;

    cnt_nz = 0;
    for (int p = 0; p <= 21; p++)
      for (int b = 0; b < 8; b++) begin
        bw = 24'(b);
        tbl.push_back('{enc(16'hFFFF) ^ (bw << p), 1'b1, 16'hFFFF, b != 0, 1'b0});
        if (b != 0) cnt_nz++;
      end
    tbl.push_back('{enc(16'hA5C3), 1'b1, 16'hA5C3, 1'b0, 1'b0});
    tbl.push_back('{enc(16'h0000) ^ 24'hE00000, 1'b1, 16'h0000, 1'b1, 1'b0});
    tbl.push_back('{enc(16'h1234) ^ (24'h5 << 9), 1'b1, 16'h1234, 1'b1, 1'b0});
    tbl.push_back('{enc(16'hFFFF), 1'b0, 16'hFFFF, 1'b0, 1'b0});
    tbl.push_back('{enc(16'hFFFF) ^ 24'h800000, 1'b0, 16'h7FFF, 1'b0, 1'b1});

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_msg", {16'd0, bus.out_msg}, 32'd0);
    chk("rst_flags", {30'd0, bus.out_corr, bus.out_uncorr}, 32'd0);
    chk("rst_counters", {bus.cnt_corr, bus.cnt_uncorr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(enc(16'hFFFF), 1'b1, '{16'hFFFF, 1'b0, 1'b0});
    collect(lat, 1'b1);
    chk("clean_latency", lat, 32'd25);

    for (int v = 0; v < tbl.size(); v++) begin
      send(tbl[v].cw, tbl[v].ce, '{tbl[v].msg, tbl[v].corr, tbl[v].uncorr});
      collect(lat, 1'b1);
      chk("latency_bound", {31'd0, lat <= 60}, 32'd1);
    end
    chk("burst_cnt_corr", {16'd0, bus.cnt_corr}, 32'(cnt_nz + 2));
    chk("detect_cnt_uncorr", {16'd0, bus.cnt_uncorr}, 32'd1);

    bus.out_ready = 1'b0;
    send(enc(16'hBEEF) ^ (24'h3 << 10), 1'b1, '{16'hBEEF, 1'b1, 1'b0});
    bus.in_valid = 1'b1;
    bus.in_cw    = 24'h123456;
    bus.corr_en  = 1'b1;
    collect(lat, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_hold", {12'd0, bus.out_valid, bus.in_ready, bus.out_corr, bus.out_uncorr, bus.out_msg},
          {12'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hBEEF});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("bp_no_second_word", seen, 32'd0);
    chk("bp_scoreboard_empty", sb.size(), 32'd0);

    send(enc(16'hFFFF) ^ (24'h1 << 5), 1'b1, '{16'hFFFF, 1'b1, 1'b0});
    repeat (28) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midreset_ready_valid", {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
    chk("midreset_counters", {bus.cnt_corr, bus.cnt_uncorr}, 32'd0);
    void'(sb.pop_back());
    exp_cc = '0;
    exp_cu = '0;
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("midreset_no_partial", seen, 32'd0);
    send(enc(16'h5A5A) ^ (24'h6 << 14), 1'b1, '{16'h5A5A, 1'b1, 1'b0});
    collect(lat, 1'b1);

    force dut.cnt_corr_q = 16'hFFFD;
    @(posedge clk); #1;
    release dut.cnt_corr_q;
    exp_cc = 16'hFFFD;
    for (int w = 0; w < 3; w++) begin
      send(enc(16'hFFFF) ^ (24'h2 << (3 * w)), 1'b1, '{16'hFFFF, 1'b1, 1'b0});
      collect(lat, 1'b1);
    end
    chk("sat_cnt_corr", {16'd0, bus.cnt_corr}, 32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
